// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: divide controller state encodings and EX-stage divide op codes.
package div_ctrl_pkg;
  typedef enum logic [1:0] {
    DIV_FREE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;
  localparam logic [5:0] EXE_OP_DIV  = 6'h1a;
  localparam logic [5:0] EXE_OP_DIVU = 6'h1b;
endpackage

// File: rtl/div_ctrl_step.sv
// div_ctrl_step: one combinational restoring-division step on {partial, dividend}.
module div_ctrl_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem_i,
  input  logic [DW-1:0] dvd_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW-1:0] rem_o,
  output logic [DW-1:0] dvd_o,
  output logic          q_o
);
  logic [DW:0] sh, diff;
  assign sh    = {rem_i, dvd_i[DW-1]};
  assign diff  = sh - {1'b0, dvs_i};
  assign q_o   = sh >= {1'b0, dvs_i};
  // Either branch fits in DW bits: a kept difference is below the divisor, as is a rejected shift.
  assign rem_o = q_o ? diff[DW-1:0] : sh[DW-1:0];
  assign dvd_o = {dvd_i[DW-2:0], 1'b0};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divide controller for div/divu with stall, annul and divide-by-zero.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          div_i_start,
  input  logic          div_i_signed,
  input  logic [DW-1:0] div_i_op0,
  input  logic [DW-1:0] div_i_op1,
  input  logic          div_i_annul,
  output logic [2*DW-1:0] div_o_result,
  output logic          div_o_ready,
  output logic          div_o_stall
);
  div_state_e st_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   rem_q, dvd_q, dvs_q;
  logic            neg_quo_q, neg_rem_q, ready_q;
  logic [2*DW-1:0] result_q;
  logic [DW-1:0]   mag0, mag1, rem_nx, dvd_nx, quo_nx, quo_fin, rem_fin;
  logic            q_bit, go;
  assign go   = div_i_start && !div_i_annul;
  assign mag0 = (div_i_signed && div_i_op0[DW-1]) ? -div_i_op0 : div_i_op0;
  assign mag1 = (div_i_signed && div_i_op1[DW-1]) ? -div_i_op1 : div_i_op1;
  div_ctrl_step #(.DW(DW)) u_step (
    .rem_i(rem_q),
    .dvd_i(dvd_q),
    .dvs_i(dvs_q),
    .rem_o(rem_nx),
    .dvd_o(dvd_nx),
    .q_o  (q_bit)
  );
  assign quo_nx  = dvd_nx | DW'(q_bit);
  assign quo_fin = neg_quo_q ? -quo_nx : quo_nx;
  assign rem_fin = neg_rem_q ? -rem_nx : rem_nx;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      st_q      <= DIV_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      case (st_q)
        DIV_FREE: if (go) begin
          st_q      <= (div_i_op1 == '0) ? DIV_ZERO : DIV_ON;
          dvd_q     <= (div_i_op1 == '0) ? div_i_op0 : mag0;
          dvs_q     <= mag1;
          rem_q     <= '0;
          cnt_q     <= '0;
          neg_quo_q <= div_i_signed && (div_i_op0[DW-1] ^ div_i_op1[DW-1]);
          neg_rem_q <= div_i_signed && div_i_op0[DW-1];
        end
        DIV_ZERO: if (div_i_annul) st_q <= DIV_FREE;
        else begin
          st_q     <= DIV_END;
          ready_q  <= 1'b1;
          result_q <= {dvd_q, {DW{1'b1}}};
        end
        DIV_ON: if (div_i_annul) st_q <= DIV_FREE;
        else begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW-1)) begin
            st_q     <= DIV_END;
            ready_q  <= 1'b1;
            result_q <= {rem_fin, quo_fin};
          end
        end
        DIV_END: if (!div_i_start) begin
          st_q     <= DIV_FREE;
          ready_q  <= 1'b0;
          result_q <= '0;
        end
        default: st_q <= DIV_FREE;
      endcase
    end
  end
  assign div_o_result = result_q;
  assign div_o_ready  = ready_q;
  // Gated by reset so the stall request drops the moment reset asserts, even with start held.
  assign div_o_stall  = rst_ && ((st_q == DIV_FREE && go) || st_q == DIV_ZERO || st_q == DIV_ON);
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl covering latency, signs, zero divide, annul and reset.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst_;
  logic        div_i_start, div_i_signed, div_i_annul;
  logic [31:0] div_i_op0, div_i_op1;
  logic [63:0] div_o_result;
  logic        div_o_ready, div_o_stall;
  int checks = 0, errors = 0;
  logic [63:0] sb[$];

  div_ctrl #(.DW(32), .CW(6)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .div_i_start (div_i_start),
    .div_i_signed(div_i_signed),
    .div_i_op0   (div_i_op0),
    .div_i_op1   (div_i_op1),
    .div_i_annul (div_i_annul),
    .div_o_result(div_o_result),
    .div_o_ready (div_o_ready),
    .div_o_stall (div_o_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
    logic [31:0] ma, mb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    q = ma / mb;
    r = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(logic [31:0] a, logic [31:0] b, logic s, bit push, logic [63:0] exp);
    div_i_op0 = a;
    div_i_op1 = b;
    div_i_signed = s;
    div_i_start = 1'b1;
    if (push) sb.push_back(exp);
  endtask

  // Cycle 0 is the current cycle (start already driven); operands are scrambled in cycle 1.
  task automatic wait_done(int lat, bit hold);
    bit done = 1'b0;
    for (int c = 0; c <= 40 && !done; c++) begin
      if (c > 0) edge1();
      if (c == 1) begin
        div_i_op0 = $urandom;
        div_i_op1 = $urandom;
        div_i_signed = 1'($urandom);
      end
      #1;
      if (div_o_ready) begin
        chk("latency", 64'(c), 64'(lat));
        chk("result", div_o_result, sb.size() > 0 ? sb.pop_front() : 64'hx);
        chk("stall_end", 64'(div_o_stall), 64'd0);
        done = 1'b1;
      end else chk("stall_busy", 64'(div_o_stall), 64'd1);
    end
    if (!done) begin
      chk("timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (hold) begin
      repeat (3) begin
        edge1();
        #1;
        chk("hold_ready", 64'(div_o_ready), 64'd1);
        chk("hold_stall", 64'(div_o_stall), 64'd0);
      end
    end
    edge1();
    div_i_start = 1'b0;
    #1;
    chk("ready_until_release", 64'(div_o_ready), 64'd1);
    edge1();
    #1;
    chk("ready_after_release", 64'(div_o_ready), 64'd0);
    chk("result_after_release", div_o_result, 64'd0);
    chk("stall_after_release", 64'(div_o_stall), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic s;
    rst_ = 1'b0;
    div_i_start = 1'b0;
    div_i_signed = 1'b0;
    div_i_annul = 1'b0;
    div_i_op0 = '0;
    div_i_op1 = '0;
    #3;
    chk("rst_ready", 64'(div_o_ready), 64'd0);
    chk("rst_result", div_o_result, 64'd0);
    chk("rst_stall", 64'(div_o_stall), 64'd0);
    edge1();
    rst_ = 1'b1;

    edge1(); launch(32'd100, 32'd7, 1'b0, 1, {32'd2, 32'd14}); wait_done(33, 1);
    edge1(); launch(32'hFFFF_FFF9, 32'h2, 1'b1, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); wait_done(33, 0);
    edge1(); launch(32'h7, 32'hFFFF_FFFE, 1'b1, 1, {32'h1, 32'hFFFF_FFFD}); wait_done(33, 0);
    edge1(); launch(32'h1234, 32'h0, 1'b0, 1, {32'h0000_1234, 32'hFFFF_FFFF}); wait_done(2, 0);
    edge1(); launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, {32'h0, 32'h8000_0000}); wait_done(33, 0);
    edge1(); launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, {32'h8000_0000, 32'h0}); wait_done(33, 0);

    edge1();
    launch(32'd5, 32'd1, 1'b0, 0, '0);
    div_i_annul = 1'b1;
    #1;
    chk("annul_blocks_start_stall", 64'(div_o_stall), 64'd0);
    edge1();
    #1;
    chk("annul_blocks_start_state", 64'(div_o_stall), 64'd0);
    div_i_start = 1'b0;
    div_i_annul = 1'b0;

    edge1();
    launch(32'd100, 32'd7, 1'b0, 0, '0);
    for (int c = 1; c <= 10; c++) begin
      edge1();
      if (c == 10) div_i_annul = 1'b1;
      #1;
      chk("annul_run_stall", 64'(div_o_stall), 64'd1);
      chk("annul_run_ready", 64'(div_o_ready), 64'd0);
    end
    edge1();
    div_i_start = 1'b0;
    div_i_annul = 1'b0;
    #1;
    chk("annul_free_stall", 64'(div_o_stall), 64'd0);
    chk("annul_free_ready", 64'(div_o_ready), 64'd0);
    edge1(); launch(32'd9, 32'd3, 1'b0, 1, {32'd0, 32'd3}); wait_done(33, 0);

    edge1();
    launch(32'd100, 32'd7, 1'b0, 0, '0);
    repeat (20) edge1();
    rst_ = 1'b0;
    #1;
    chk("arst_ready", 64'(div_o_ready), 64'd0);
    chk("arst_result", div_o_result, 64'd0);
    chk("arst_stall", 64'(div_o_stall), 64'd0);
    #2;
    rst_ = 1'b1;
    sb.push_back({32'd2, 32'd14});
    wait_done(33, 0);

    repeat (4) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom >> $urandom_range(0, 31);
      s = 1'($urandom);
      edge1();
      launch(a, b, s, 1, model(a, b, s));
      wait_done(b == 0 ? 2 : 33, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide controller for the EX stage. Handles the div and divu instructions that ID decodes.
- Captures the operands on start and runs one restoring-division step per cycle for DW cycles. While it runs it raises a pipeline stall request.
- Returns {remainder, quotient} for the HI/LO write.
- Supports annul from branch/exception flush and reports divide-by-zero without iterating.

Parameters:
- DW, 32, operand width; the iteration count equals DW.
- CW, 6, iteration counter width; must satisfy 2^CW > DW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- div_i_start  in  1  divide request from EX; level, held until ready is seen.
- div_i_signed  in  1  1 = div (signed), 0 = divu.
- div_i_op0  in  DW  dividend (rs).
- div_i_op1  in  DW  divisor (rt).
- div_i_annul  in  1  flush; abort any operation in flight.
- div_o_result  out  2*DW  {remainder, quotient}; upper half goes to HI, lower half to LO.
- div_o_ready  out  1  result valid.
- div_o_stall  out  1  stall request to the pipeline controller.

Behaviour:
- Reset (rst_=0, async): state=FREE; counter, working registers, div_o_result, div_o_ready and div_o_stall all 0. Reset mid-operation discards the operation.
- States: FREE, ZERO, ON, END; registered.
- FREE:
  - start & !annul & op1==0: go to ZERO.
  - start & !annul & op1!=0: go to ON. Latch |op0| and |op1| (two's-complement magnitude when signed, raw values when unsigned), latch the quotient and remainder sign flags, clear the partial remainder, counter=0.
  - Otherwise stay in FREE.
- ON:
  - Each cycle performs one restoring step: shift {partial, dividend} left by 1, trial-subtract the divisor, and on no borrow keep the difference and set quotient bit = 1.
  - counter increments every cycle; after the step with counter==DW-1, go to END.
  - When leaving ON, apply signs: quotient is negated if the operand signs differ (signed only); remainder takes the dividend's sign.
- ZERO: go to END next cycle with result = {op0, {DW{1'b1}}}. This value is architecturally undefined but fixed for verification.
- END: div_o_ready=1 and div_o_result is held. When start deasserts, go to FREE next cycle; ready and result then return to 0.
- Annul: in ZERO or ON, annul=1 forces FREE next cycle; result stays 0 and ready never asserts. In END or FREE, annul is ignored, except that FREE does not start while annul=1.
- Stall (combinational): div_o_stall = (FREE & start & !annul) | ZERO | ON. It is 0 in END so the instruction can advance.
- Latency, with start first seen in cycle 0:
  - Normal divide: ON for cycles 1..DW, END (ready) at cycle DW+1, i.e. 33 for DW=32. Stall asserted in cycles 0..DW.
  - Divide-by-zero: ready at cycle 2.
- Operands are sampled only in FREE; later changes on op0/op1/signed are ignored until the next start.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) and remainder 0, with no trap.
- Unsigned mode never negates.
- Start held high after END without a deassert: the controller stays in END and does not restart.

Decomposition:
- Shared package (alongside the EXE_OP_* defines): DIV_FREE, DIV_ZERO, DIV_ON, DIV_END 2-bit state encodings, and EXE_OP_DIV/EXE_OP_DIVU op codes.
- Sub-module div_step: combinational single restoring step. Takes partial remainder, dividend and divisor; outputs next partial remainder, next dividend and quotient bit.
- div_ctrl owns the FSM, counter, sign fix-up and handshake.

Test Plan:
- Unsigned 100/7, start held: stall high cycles 0-32; ready at cycle 33; result = {32'd2, 32'd14}. Deassert start: ready=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x2): result = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2: result = {0x1, 0xFFFFFFFD}.
- Divide-by-zero, op0=0x1234, op1=0: ready at cycle 2; result = {0x00001234, 0xFFFFFFFF}; stall only in cycles 0-1.
- Annul asserted at cycle 10 of a 100/7 divide: FREE at cycle 11, ready never asserts, stall=0 from cycle 11. A new start at cycle 12 of 9/3 gives {0, 3} at cycle 45.
- Signed 0x80000000 / 0xFFFFFFFF: result = {0x0, 0x80000000}. Same operands unsigned: result = {0x80000000, 0x0}.
- Async reset pulsed at cycle 20 of an operation: outputs 0 immediately, state FREE. After release, with start still high, a new operation begins.
